fifo_rr_scheduler: RTL and testbench

- Shares one 8-bit synchronous FIFO (registered dout, 1-cycle read latency, combinational full/empty) among NREQ producers and one consumer.
- Write side: a round-robin arbiter grants at most one producer per cycle into the FIFO and never writes while the FIFO is full.
- Read side: a small FSM drains the FIFO into a valid/ready output register.
- Sits between producer agents and the shared FIFO instance; also provides occupancy statistics.

---
 rtl/fifo_rr_scheduler_if.sv | 36 +++
 rtl/fifo_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of the scheduler's producer, FIFO, consumer and statistics signals.
// The scheduler uses the master view. The environment (producers, FIFO, consumer) uses slave.
interface fifo_rr_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_din;
  logic                  fifo_full;
  logic                  fifo_rd_en;
  logic [WIDTH-1:0]      fifo_dout;
  logic                  fifo_empty;
  logic                  drain_en;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [CNT_W-1:0]      wr_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    input  req, req_data, fifo_full, fifo_dout, fifo_empty, drain_en, out_ready,
    output gnt, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data,
           wr_cnt, rd_cnt, stall_cnt
  );

  modport slave (
    output req, req_data, fifo_full, fifo_dout, fifo_empty, drain_en, out_ready,
    input  gnt, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data,
           wr_cnt, rd_cnt, stall_cnt
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter and drain FSM around one shared synchronous FIFO.
// The FIFO has a registered dout, so a read issued in cycle N is captured in N+1
// and is presented on out_data/out_valid from N+2.
module fifo_rr_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  fifo_rr_scheduler_if.master bus
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHold} rd_state_e;

  logic [PTR_W-1:0] prio_q, prio_d;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic             wr_en;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] din;

  rd_state_e        state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             rd_en;

  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q, stall_cnt_q;

  // Find the first requester at or after the priority pointer, wrapping modulo NREQ.
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, prio_q} + SUM_W'(k);
      if (sum >= SUM_W'(NREQ)) begin
        sum = sum - SUM_W'(NREQ);
      end
      if (!win_found && bus.req[sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[PTR_W-1:0];
      end
    end
  end

  // Write decision; reset suppresses grants so nothing is written in the reset cycle.
  always_comb begin
    wr_en  = (|bus.req) && !bus.fifo_full && !rst;
    gnt    = wr_en ? (NREQ'(1) << win_idx) : '0;
    din    = win_found ? bus.req_data[win_idx*WIDTH +: WIDTH] : '0;
    prio_d = prio_q;
    if (wr_en) begin
      prio_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // Priority pointer: moves past the winner only when a write actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Drain FSM next state: read, capture registered dout, then hold until accepted.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.drain_en && !bus.fifo_empty) begin
          rd_en   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        out_data_d  = bus.fifo_dout;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          // Back-to-back read on acceptance gives one item every two cycles.
          if (bus.drain_en && !bus.fifo_empty) begin
            rd_en   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Drain FSM and output register state; reset discards any item in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      if (out_valid_q && bus.out_ready) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if ((|bus.req) && bus.fifo_full) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.gnt        = gnt;
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = din;
  assign bus.fifo_rd_en = rd_en && !rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.wr_cnt     = wr_cnt_q;
  assign bus.rd_cnt     = rd_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: a depth-4 FIFO model, directed scenarios and a random phase,
// all checked against a transaction-level model (pointer arithmetic plus a data scoreboard).
module tb_fifo_rr_scheduler;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fifo_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared FIFO stand-in: registered dout, combinational full/empty.
  logic [WIDTH-1:0] fmem [DEPTH];
  logic [1:0]       fwp, frp;
  int               fcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fwp           <= '0;
      frp           <= '0;
      fcnt          <= 0;
      bus.fifo_dout <= '0;
    end else begin
      if (bus.fifo_rd_en && fcnt > 0) begin
        bus.fifo_dout <= fmem[frp];
        frp           <= frp + 2'd1;
      end
      if (bus.fifo_wr_en && fcnt < DEPTH) begin
        fmem[fwp] <= bus.fifo_din;
        fwp       <= fwp + 2'd1;
      end
      fcnt <= fcnt + ((bus.fifo_wr_en && fcnt < DEPTH) ? 1 : 0)
                   - ((bus.fifo_rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  assign bus.fifo_full  = (fcnt == DEPTH);
  assign bus.fifo_empty = (fcnt == 0);

  // Reference model state.
  int               m_ptr;
  logic [CNT_W-1:0] m_wr, m_rd, m_stall;
  logic [WIDTH-1:0] sb[$];
  bit               m_fetch, m_shown;
  logic [WIDTH-1:0] m_fetch_data, m_show_data;
  logic [NREQ-1:0]  last_gnt;

  // Per-cycle observations for the directed scenarios.
  logic [NREQ-1:0]  obs_gnt;
  logic             obs_wr, obs_rd, obs_valid, obs_hs;
  logic [WIDTH-1:0] obs_out;
  logic [NREQ-1:0]  gq[$];
  logic [WIDTH-1:0] oq[$];
  logic             wq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_wr     = '0;
    m_rd     = '0;
    m_stall  = '0;
    sb.delete();
    m_fetch  = 1'b0;
    m_shown  = 1'b0;
    last_gnt = '0;
  endtask

  task automatic check_reset_state();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 0);
    check("rst_rd_cnt", 32'(bus.rd_cnt), 0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
  endtask

  // Entered at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: compare combinational and registered outputs, then advance the model.
  task automatic step();
    int               w;
    logic             full, rdy, ewr, erd;
    logic [NREQ-1:0]  eg;
    logic [WIDTH-1:0] edin;
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && bus.req[idx]) w = idx;
    end
    full = bus.fifo_full;
    rdy  = bus.out_ready;
    ewr  = (w >= 0) && !full;
    eg   = ewr ? (NREQ'(1) << w) : '0;
    edin = (w >= 0) ? bus.req_data[w*WIDTH +: WIDTH] : '0;
    erd  = bus.drain_en && !bus.fifo_empty && !m_fetch && (!m_shown || rdy);

    check("gnt", 32'(bus.gnt), 32'(eg));
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(ewr));
    check("fifo_din", 32'(bus.fifo_din), 32'(edin));
    check("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(erd));
    check("out_valid", 32'(bus.out_valid), 32'(m_shown));
    if (m_shown) check("out_data", 32'(bus.out_data), 32'(m_show_data));
    check("wr_cnt", 32'(bus.wr_cnt), 32'(m_wr));
    check("rd_cnt", 32'(bus.rd_cnt), 32'(m_rd));
    check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));

    obs_gnt   = bus.gnt;
    obs_wr    = bus.fifo_wr_en;
    obs_rd    = bus.fifo_rd_en;
    obs_valid = bus.out_valid;
    obs_out   = bus.out_data;
    obs_hs    = bus.out_valid && rdy;
    last_gnt  = eg;

    @(posedge clk);
    if (m_shown && rdy) begin
      m_shown = 1'b0;
      m_rd++;
    end
    if (m_fetch) begin
      m_shown     = 1'b1;
      m_show_data = m_fetch_data;
      m_fetch     = 1'b0;
    end
    if (erd) begin
      m_fetch      = 1'b1;
      m_fetch_data = (sb.size() > 0) ? sb.pop_front() : '0;
    end
    if (ewr) begin
      sb.push_back(edin);
      m_wr++;
      m_ptr = (w + 1) % NREQ;
    end
    if (w >= 0 && full) m_stall++;
    @(negedge clk);
  endtask

  task automatic run_collect(input int n);
    gq.delete();
    oq.delete();
    wq.delete();
    repeat (n) begin
      step();
      if (obs_gnt != '0) gq.push_back(obs_gnt);
      if (obs_hs) oq.push_back(obs_out);
      wq.push_back(obs_wr);
    end
  endtask

  task automatic set_data(input logic [WIDTH-1:0] base);
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
  endtask

  // Producers hold request and data until granted, then may re-roll both.
  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req[i] || last_gnt[i]) begin
        bus.req[i]                     = ($urandom_range(0, 99) < 60);
        bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    bus.drain_en  = ($urandom_range(0, 99) < 70);
    bus.out_ready = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b0;
    bus.req       = '1;
    bus.req_data  = '0;
    bus.drain_en  = 1'b1;
    bus.out_ready = 1'b1;
    model_reset();

    // Round-robin with all producers requesting and continuous draining.
    set_data(8'hA0);
    pulse_reset();
    run_collect(20);
    check("rr_gnt_count", 32'(gq.size() >= 5), 1);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check("rr_gnt_seq", 32'(gq[i]), 32'(4'b0001 << (i % 4)));
    check("rr_out_count", 32'(oq.size() >= 5), 1);
    for (int i = 0; i < 5 && i < oq.size(); i++)
      check("rr_out_seq", 32'(oq[i]), 32'(8'hA0 + (i % 4)));

    // Pointer skips idle requesters.
    bus.req = 4'b0101;
    pulse_reset();
    run_collect(8);
    check("skip_gnt_count", 32'(gq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("skip_gnt_seq", 32'(gq[i]), (i % 2 == 0) ? 32'h1 : 32'h4);

    // Full stall with no draining.
    bus.req       = 4'b0100;
    bus.drain_en  = 1'b0;
    bus.out_ready = 1'b0;
    pulse_reset();
    run_collect(6);
    check("full_gnt_count", 32'(gq.size()), 4);
    check("full_wr_en_5", 32'(wq[4]), 0);
    check("full_wr_en_6", 32'(wq[5]), 0);
    check("full_stall_cnt", 32'(bus.stall_cnt), 2);
    check("full_wr_cnt", 32'(bus.wr_cnt), 4);

    // Backpressure: two items queued, consumer stalls three cycles on the first.
    bus.req = '0;
    pulse_reset();
    bus.req = 4'b0001;
    bus.req_data[0 +: WIDTH] = 8'h11;
    step();
    bus.req_data[0 +: WIDTH] = 8'h22;
    step();
    bus.req      = '0;
    bus.drain_en = 1'b1;
    step();
    check("bp_first_rd", 32'(obs_rd), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 32'(obs_valid), 1);
      check("bp_hold_data", 32'(obs_out), 32'h11);
      check("bp_hold_no_rd", 32'(obs_rd), 0);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_accept_rd", 32'(obs_rd), 1);
    step();
    step();
    check("bp_second_valid", 32'(obs_valid), 1);
    check("bp_second_data", 32'(obs_out), 32'h22);
    check("bp_rd_cnt", 32'(bus.rd_cnt), 2);

    // Drain gate holds a non-empty FIFO until drain_en rises.
    bus.drain_en = 1'b0;
    pulse_reset();
    bus.req = 4'b0010;
    bus.req_data[WIDTH +: WIDTH] = 8'h55;
    step();
    bus.req_data[WIDTH +: WIDTH] = 8'h66;
    step();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gate_no_rd", 32'(obs_rd), 0);
      check("gate_no_valid", 32'(obs_valid), 0);
    end
    bus.drain_en = 1'b1;
    step();
    check("gate_open_rd", 32'(obs_rd), 1);
    step();
    check("gate_fetch_valid", 32'(obs_valid), 0);
    step();
    check("gate_out_valid", 32'(obs_valid), 1);
    check("gate_out_data", 32'(obs_out), 32'h55);

    // Random traffic against the model.
    pulse_reset();
    repeat (400) begin
      rand_inputs();
      step();
    end

    // Reset while an item is held with requests active.
    bus.req       = '1;
    bus.drain_en  = 1'b1;
    bus.out_ready = 1'b0;
    set_data(8'hC0);
    pulse_reset();
    for (int i = 0; i < 20 && !m_shown; i++) step();
    check("hold_reached", 32'(bus.out_valid), 1);
    pulse_reset();
    step();
    check("restart_gnt", 32'(obs_gnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
